// File: rtl/bidir_shift_tx_pkg.sv
// Shared definitions for the bidirectional shift transmitter/receiver pair.
// Direction codes match the receiver's mode input encoding.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_LSB_FIRST = 1'b1;
  localparam logic DIR_MSB_FIRST = 1'b0;

endpackage

// File: rtl/bidir_shift_tx_if.sv
// Word-load handshake between a data source and the serial transmitter.
// The source drives the word and direction; the transmitter returns ready.
interface bidir_shift_tx_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             mode;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output din,
    output mode,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  din,
    input  mode,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/bidir_shift_tx.sv
// Parallel-in serial-out transmitter, one bit per clock, direction chosen at load.
// Every output comes straight from a flop.
module bidir_shift_tx
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  bidir_shift_tx_if.slave  lif,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             load_ready_q, load_ready_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             done_q, done_d;

  function automatic logic tx_bit(
    input logic [WIDTH-1:0] w,
    input logic             d
  );
    return (d == DIR_LSB_FIRST) ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(
    input logic [WIDTH-1:0] w,
    input logic             d
  );
    return (d == DIR_LSB_FIRST) ? (w >> 1) : (w << 1);
  endfunction

  // Next-state: sout_q always mirrors the outgoing end of sreg_q
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    load_ready_d = load_ready_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready_d = 1'b1;
        if (lif.load_valid && load_ready_q) begin
          sreg_d       = lif.din;
          dir_d        = lif.mode;
          cnt_d        = '0;
          state_d      = SHIFT;
          load_ready_d = 1'b0;
          sout_d       = tx_bit(lif.din, lif.mode);
          sout_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        sreg_d = shift_out(sreg_q, dir_q);
        if (cnt_q == LAST) begin
          state_d      = IDLE;
          load_ready_d = 1'b1;
          done_d       = 1'b1;
        end else begin
          cnt_d        = cnt_q + 1'b1;
          sout_d       = tx_bit(sreg_d, dir_q);
          sout_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        load_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers, reset wins over any load
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      dir_q        <= DIR_MSB_FIRST;
      load_ready_q <= 1'b1;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      load_ready_q <= load_ready_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end

  assign lif.load_ready = load_ready_q;
  assign sout           = sout_q;
  assign sout_valid     = sout_valid_q;
  assign done           = done_q;

endmodule
